// File: rtl/clkseq_pkg.sv
// Shared types and constants for the clock domain sequencer.
package clkseq_pkg;

    typedef enum logic [2:0] {
        BOOT       = 3'd0,
        IDLE       = 3'd1,
        UP_SETTLE  = 3'd2,
        UP_RELEASE = 3'd3,
        DN_HOLD    = 3'd4,
        DN_GATE    = 3'd5,
        DONE       = 3'd6
    } clkseq_state_e;

    localparam int DEFAULT_SETTLE_CYCLES = 4;
    localparam int DEFAULT_HOLD_CYCLES   = 8;

    // Bits needed to hold a count of max_val; never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clkseq_timer.sv
// Loadable down-counter; expired is high whenever the count sits at zero.
module clkseq_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/clock_domain_sequencer.sv
// Sequences clock-enable / reset of N broadcast domains one at a time.
// Define CLKSEQ_BOOT_EN to bring every domain up in index order after reset.
//
// state      | meaning
// BOOT       | first cycle after reset, starts domain 0 (boot build only)
// IDLE       | req_ready high, waiting for a request
// UP_SETTLE  | clock enabled, domain still in reset, counting settle time
// UP_RELEASE | domain reset released
// DN_HOLD    | domain reset asserted with clock running, counting hold time
// DN_GATE    | clock gated
// DONE       | done pulse, dom_on updated
module clock_domain_sequencer
    import clkseq_pkg::*;
#(
    parameter int N_DOMAINS     = 5,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [$clog2(N_DOMAINS)-1:0] req_domain,
    input  logic                         req_on,
    output logic                         done_valid,
    output logic [$clog2(N_DOMAINS)-1:0] done_domain,
    output logic [N_DOMAINS-1:0]         clk_en,
    output logic [N_DOMAINS-1:0]         dom_reset,
    output logic [N_DOMAINS-1:0]         dom_on
);

    localparam int DW   = $clog2(N_DOMAINS);
    localparam int TMAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int TW   = cnt_width(TMAX);

    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);

`ifdef CLKSEQ_BOOT_EN
    localparam clkseq_state_e RESET_STATE = BOOT;
`else
    localparam clkseq_state_e RESET_STATE = IDLE;
`endif

    clkseq_state_e state_q, state_d;
    logic [DW-1:0]        dom_q, dom_d;
    logic [N_DOMAINS-1:0] sel_q, sel_d;
    logic [N_DOMAINS-1:0] clk_en_q, clk_en_d;
    logic [N_DOMAINS-1:0] dom_reset_q, dom_reset_d;
    logic [N_DOMAINS-1:0] dom_on_q, dom_on_d;
    logic                 done_valid_q, done_valid_d;
    logic [DW-1:0]        done_domain_q, done_domain_d;
    logic                 req_ready_q, req_ready_d;
`ifdef CLKSEQ_BOOT_EN
    logic                 boot_q, boot_d;
`endif

    logic [N_DOMAINS-1:0] req_sel;
    logic                 req_redundant;
    logic                 tmr_load;
    logic [TW-1:0]        tmr_val;
    logic                 tmr_expired;

    clkseq_timer #(.W(TW)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // An out-of-range index decodes to an empty mask and is handled as redundant.
    always_comb begin
        req_sel = '0;
        for (int i = 0; i < N_DOMAINS; i++) begin
            req_sel[i] = (req_domain == DW'(i));
        end
    end

    assign req_redundant = (req_sel == '0) || ((|(dom_on_q & req_sel)) == req_on);

    always_comb begin
        state_d       = state_q;
        dom_d         = dom_q;
        sel_d         = sel_q;
        clk_en_d      = clk_en_q;
        dom_reset_d   = dom_reset_q;
        dom_on_d      = dom_on_q;
        done_domain_d = done_domain_q;
`ifdef CLKSEQ_BOOT_EN
        boot_d        = boot_q;
`endif
        tmr_load      = 1'b0;
        tmr_val       = '0;

        case (state_q)
`ifdef CLKSEQ_BOOT_EN
            BOOT: begin
                dom_d    = '0;
                sel_d    = N_DOMAINS'(1);
                clk_en_d = clk_en_q | N_DOMAINS'(1);
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LOAD;
                state_d  = UP_SETTLE;
            end
`endif
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    dom_d = req_domain;
                    sel_d = req_sel;
                    if (req_redundant) begin
                        done_domain_d = req_domain;
                        state_d       = DONE;
                    end else if (req_on) begin
                        clk_en_d = clk_en_q | req_sel;
                        tmr_load = 1'b1;
                        tmr_val  = SETTLE_LOAD;
                        state_d  = UP_SETTLE;
                    end else begin
                        dom_reset_d = dom_reset_q | req_sel;
                        tmr_load    = 1'b1;
                        tmr_val     = HOLD_LOAD;
                        state_d     = DN_HOLD;
                    end
                end
            end
            UP_SETTLE: begin
                if (tmr_expired) begin
                    dom_reset_d = dom_reset_q & ~sel_q;
                    state_d     = UP_RELEASE;
                end
            end
            UP_RELEASE: begin
                dom_on_d      = dom_on_q | sel_q;
                done_domain_d = dom_q;
                state_d       = DONE;
            end
            DN_HOLD: begin
                if (tmr_expired) begin
                    clk_en_d = clk_en_q & ~sel_q;
                    state_d  = DN_GATE;
                end
            end
            DN_GATE: begin
                dom_on_d      = dom_on_q & ~sel_q;
                done_domain_d = dom_q;
                state_d       = DONE;
            end
            DONE: begin
`ifdef CLKSEQ_BOOT_EN
                // During boot the next domain starts on the edge that ends this pulse.
                if (boot_q && (dom_q != DW'(N_DOMAINS - 1))) begin
                    dom_d    = dom_q + DW'(1);
                    sel_d    = sel_q << 1;
                    clk_en_d = clk_en_q | (sel_q << 1);
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LOAD;
                    state_d  = UP_SETTLE;
                end else begin
                    boot_d  = 1'b0;
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        done_valid_d = (state_d == DONE);
        req_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= RESET_STATE;
            dom_q         <= '0;
            sel_q         <= '0;
            clk_en_q      <= '0;
            dom_reset_q   <= '1;
            dom_on_q      <= '0;
            done_valid_q  <= 1'b0;
            done_domain_q <= '0;
            req_ready_q   <= 1'b0;
`ifdef CLKSEQ_BOOT_EN
            boot_q        <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            dom_q         <= dom_d;
            sel_q         <= sel_d;
            clk_en_q      <= clk_en_d;
            dom_reset_q   <= dom_reset_d;
            dom_on_q      <= dom_on_d;
            done_valid_q  <= done_valid_d;
            done_domain_q <= done_domain_d;
            req_ready_q   <= req_ready_d;
`ifdef CLKSEQ_BOOT_EN
            boot_q        <= boot_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign done_valid  = done_valid_q;
    assign done_domain = done_domain_q;
    assign clk_en      = clk_en_q;
    assign dom_reset   = dom_reset_q;
    assign dom_on      = dom_on_q;

endmodule

// File: tb/tb_clock_domain_sequencer.sv
// Directed bench for clock_domain_sequencer: N=5, SETTLE=4, HOLD=8.
// Snapshot order is {clk_en, dom_reset, dom_on, done_valid, req_ready}.
module tb_clock_domain_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_domain = 3'd0;
    logic       req_on = 1'b0;
    logic       done_valid;
    logic [2:0] done_domain;
    logic [4:0] clk_en;
    logic [4:0] dom_reset;
    logic [4:0] dom_on;

    int n_checks = 0;
    int n_pass   = 0;

    clock_domain_sequencer #(
        .N_DOMAINS     (5),
        .SETTLE_CYCLES (4),
        .HOLD_CYCLES   (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_domain  (req_domain),
        .req_on      (req_on),
        .done_valid  (done_valid),
        .done_domain (done_domain),
        .clk_en      (clk_en),
        .dom_reset   (dom_reset),
        .dom_on      (dom_on)
    );

    always #5 clock = ~clock;

    task automatic issue(input logic [2:0] d, input logic on);
        @(negedge clock);
        req_domain = d;
        req_on     = on;
        req_valid  = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_checks++;
        if ({clk_en, dom_reset, dom_on, done_valid, req_ready} !== {5'b00000, 5'b11111, 5'b00000, 1'b0, 1'b0})
            $display("FAIL reset_values got %b want %b", {clk_en, dom_reset, dom_on, done_valid, req_ready},
                     {5'b00000, 5'b11111, 5'b00000, 1'b0, 1'b0});
        else n_pass++;
        n_checks++;
        if (done_domain !== 3'd0) $display("FAIL reset_done_domain got %0d want 0", done_domain);
        else n_pass++;
        reset = 1'b1;
    endtask

`ifdef CLKSEQ_BOOT_EN
    task automatic test_boot();
        logic [1:0] want;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clock);
            want = {(k % 6 == 0), (k >= 31)};
            n_checks++;
            if ({done_valid, req_ready} !== want)
                $display("FAIL boot_done_ready k=%0d got %b want %b", k, {done_valid, req_ready}, want);
            else n_pass++;
            if (k % 6 == 0) begin
                n_checks++;
                if (done_domain !== 3'(k / 6 - 1))
                    $display("FAIL boot_done_domain k=%0d got %0d want %0d", k, done_domain, k / 6 - 1);
                else n_pass++;
            end
            if (k == 1) begin
                n_checks++;
                if (clk_en !== 5'b00001) $display("FAIL boot_first_clk_en got %b want 00001", clk_en);
                else n_pass++;
            end
        end
        n_checks++;
        if ({clk_en, dom_reset, dom_on} !== {5'b11111, 5'b00000, 5'b11111})
            $display("FAIL boot_final got %b want %b", {clk_en, dom_reset, dom_on}, {5'b11111, 5'b00000, 5'b11111});
        else n_pass++;
    endtask
`else
    task automatic test_ready_after_reset();
        @(negedge clock);
        n_checks++;
        if ({clk_en, dom_reset, dom_on, done_valid, req_ready} !== {5'b00000, 5'b11111, 5'b00000, 1'b0, 1'b1})
            $display("FAIL ready_after_reset got %b want %b", {clk_en, dom_reset, dom_on, done_valid, req_ready},
                     {5'b00000, 5'b11111, 5'b00000, 1'b0, 1'b1});
        else n_pass++;
    endtask

    task automatic test_up();
        logic [16:0] want;
        issue(3'd2, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            want = {5'b00100, (k >= 5) ? 5'b11011 : 5'b11111, (k >= 6) ? 5'b00100 : 5'b00000, (k == 6), (k >= 7)};
            n_checks++;
            if ({clk_en, dom_reset, dom_on, done_valid, req_ready} !== want)
                $display("FAIL up k=%0d got %b want %b", k, {clk_en, dom_reset, dom_on, done_valid, req_ready}, want);
            else n_pass++;
            if (k == 6) begin
                n_checks++;
                if (done_domain !== 3'd2) $display("FAIL up_done_domain got %0d want 2", done_domain);
                else n_pass++;
            end
        end
    endtask

    task automatic test_down();
        logic [16:0] want;
        issue(3'd2, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clock);
            want = {(k >= 9) ? 5'b00000 : 5'b00100, 5'b11111, (k >= 10) ? 5'b00000 : 5'b00100, (k == 10), (k >= 11)};
            n_checks++;
            if ({clk_en, dom_reset, dom_on, done_valid, req_ready} !== want)
                $display("FAIL down k=%0d got %b want %b", k, {clk_en, dom_reset, dom_on, done_valid, req_ready}, want);
            else n_pass++;
            if (k == 10) begin
                n_checks++;
                if (done_domain !== 3'd2) $display("FAIL down_done_domain got %0d want 2", done_domain);
                else n_pass++;
            end
        end
    endtask

    task automatic test_redundant(input logic [2:0] d, input logic on);
        logic [16:0] want;
        issue(d, on);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clock);
            want = {5'b00000, 5'b11111, 5'b00000, (k == 1), (k == 2)};
            n_checks++;
            if ({clk_en, dom_reset, dom_on, done_valid, req_ready} !== want)
                $display("FAIL redundant d=%0d k=%0d got %b want %b", d, k,
                         {clk_en, dom_reset, dom_on, done_valid, req_ready}, want);
            else n_pass++;
            if (k == 1) begin
                n_checks++;
                if (done_domain !== d) $display("FAIL redundant_done_domain got %0d want %0d", done_domain, d);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] want;
        @(negedge clock);
        req_domain = 3'd1;
        req_on     = 1'b1;
        req_valid  = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            want = {(k >= 8) ? 5'b01010 : 5'b00010,
                    (k >= 12) ? 5'b10101 : ((k >= 5) ? 5'b11101 : 5'b11111),
                    (k >= 13) ? 5'b01010 : ((k >= 6) ? 5'b00010 : 5'b00000),
                    (k == 6) || (k == 13), (k == 7) || (k >= 14)};
            n_checks++;
            if ({clk_en, dom_reset, dom_on, done_valid, req_ready} !== want)
                $display("FAIL back_to_back k=%0d got %b want %b", k,
                         {clk_en, dom_reset, dom_on, done_valid, req_ready}, want);
            else n_pass++;
            if (k == 6 || k == 13) begin
                n_checks++;
                if (done_domain !== ((k == 6) ? 3'd1 : 3'd3))
                    $display("FAIL back_to_back_done_domain k=%0d got %0d want %0d", k, done_domain,
                             (k == 6) ? 1 : 3);
                else n_pass++;
            end
            if (k == 1) req_domain = 3'd3;
            if (k == 8) req_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] want;
        issue(3'd4, 1'b1);
        repeat (3) @(negedge clock);
        n_checks++;
        if ({clk_en, dom_reset, dom_on, done_valid, req_ready} !== {5'b11010, 5'b10101, 5'b01010, 1'b0, 1'b0})
            $display("FAIL mid_before_reset got %b want %b", {clk_en, dom_reset, dom_on, done_valid, req_ready},
                     {5'b11010, 5'b10101, 5'b01010, 1'b0, 1'b0});
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({clk_en, dom_reset, dom_on, done_valid, req_ready, done_domain} !==
            {5'b00000, 5'b11111, 5'b00000, 1'b0, 1'b0, 3'd0})
            $display("FAIL mid_reset_immediate got %b want %b",
                     {clk_en, dom_reset, dom_on, done_valid, req_ready, done_domain},
                     {5'b00000, 5'b11111, 5'b00000, 1'b0, 1'b0, 3'd0});
        else n_pass++;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({clk_en, dom_reset, dom_on, done_valid, req_ready} !== {5'b00000, 5'b11111, 5'b00000, 1'b0, 1'b1})
            $display("FAIL mid_after_release got %b want %b", {clk_en, dom_reset, dom_on, done_valid, req_ready},
                     {5'b00000, 5'b11111, 5'b00000, 1'b0, 1'b1});
        else n_pass++;
        issue(3'd4, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            want = {5'b10000, (k >= 5) ? 5'b01111 : 5'b11111, (k >= 6) ? 5'b10000 : 5'b00000, (k == 6), (k >= 7)};
            n_checks++;
            if ({clk_en, dom_reset, dom_on, done_valid, req_ready} !== want)
                $display("FAIL restart k=%0d got %b want %b", k, {clk_en, dom_reset, dom_on, done_valid, req_ready}, want);
            else n_pass++;
            if (k == 6) begin
                n_checks++;
                if (done_domain !== 3'd4) $display("FAIL restart_done_domain got %0d want 4", done_domain);
                else n_pass++;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef CLKSEQ_BOOT_EN
        test_boot();
`else
        test_ready_after_reset();
        test_up();
        test_down();
        test_redundant(3'd0, 1'b0);
        test_redundant(3'd6, 1'b1);
        test_back_to_back();
        test_reset_mid();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_domain_sequencer.md
# clock_domain_sequencer

Power/clock sequencer sitting in front of the fixed clock broadcast node that fans one clock/reset pair out to N downstream domains. Per domain it drives a clock-gate enable and a synchronous-style active-high domain reset, and it brings domains up or down one at a time through an ordered, timed sequence. Requests arrive on a single valid/ready channel. An optional boot mode brings every domain up in index order after reset.

## Interface
Parameters:
- N_DOMAINS, 5, number of broadcast outputs sequenced.
- SETTLE_CYCLES, 4, cycles between a clock-enable change and the next reset change; must be ≥1.
- HOLD_CYCLES, 8, cycles reset is held asserted with the clock running before gating; must be ≥1.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_domain  in  $clog2(N_DOMAINS)  target domain index.
- req_on  in  1  1 = bring up, 0 = take down.
- done_valid  out  1  one-cycle pulse: a sequence completed.
- done_domain  out  $clog2(N_DOMAINS)  domain of completed sequence; valid with done_valid.
- clk_en  out  N_DOMAINS  per-domain clock-gate enable.
- dom_reset  out  N_DOMAINS  per-domain reset, active-high.
- dom_on  out  N_DOMAINS  per-domain status, 1 = up.

## Operation
- Reset values (asserted asynchronously): clk_en=0, dom_reset=all 1s, dom_on=0, done_valid=0, done_domain=0, req_ready=0, FSM=IDLE (or BOOT with macro).
- FSM states: BOOT, IDLE, UP_SETTLE, UP_RELEASE, DN_HOLD, DN_GATE, DONE.
- IDLE: req_ready=1; only state accepting requests. Accept on req_valid&&req_ready.
- Up sequence: UP_SETTLE sets clk_en[d]=1, counts SETTLE_CYCLES; UP_RELEASE clears dom_reset[d]; DONE pulses done_valid, sets dom_on[d]=1, returns to IDLE (or BOOT).
- Down sequence: DN_HOLD sets dom_reset[d]=1, counts HOLD_CYCLES; DN_GATE clears clk_en[d]; DONE pulses, clears dom_on[d].
- Redundant request (req_on equals dom_on[d]): go straight to DONE; no change on clk_en/dom_reset; done still pulses.
- req_domain ≥ N_DOMAINS: accepted, treated as redundant (done pulses with that index, no output changes).
- Only one sequence in flight; other domains' outputs never change during it.
- Invariant: dom_reset[d]=0 implies clk_en[d]=1.
- Reset mid-sequence: all outputs return immediately to reset values; partial sequence discarded.

## Timing
- Request accepted at edge T, up: clk_en[d]=1 from T+1; dom_reset[d]=0 from T+1+SETTLE_CYCLES; done_valid and dom_on[d]=1 at T+2+SETTLE_CYCLES; req_ready=1 from T+3+SETTLE_CYCLES.
- Down: dom_reset[d]=1 from T+1; clk_en[d]=0 from T+1+HOLD_CYCLES; done at T+2+HOLD_CYCLES.
- Redundant: done at T+1; req_ready again at T+2.
- All outputs registered; no combinational path from req_* to any output except none (req_ready depends on state only).

## Configuration
- CLKSEQ_BOOT_EN defined: after reset deasserts, FSM runs BOOT, bringing domains 0..N_DOMAINS-1 up in order; domain k+1 starts on the edge where domain k's done pulses; each pulses done_valid; req_ready=0 until boot completes, then IDLE.
- Undefined: FSM starts in IDLE; all domains stay gated and in reset until requested; BOOT state absent.

## Structure
- Shared package clkseq_pkg: FSM state enum, default SETTLE/HOLD constants, counter width function.
- One sub-module: clkseq_timer, loadable down-counter with expiry flag, instantiated once and reloaded per phase.

## Test plan
- No boot, SETTLE=4: req (d=2, on=1) at T -> clk_en[2] rises T+1, dom_reset[2] falls T+5, done_valid with done_domain=2 at T+6.
- Down after up, HOLD=8: req (d=2, on=0) at T -> dom_reset[2]=1 at T+1, clk_en[2]=0 at T+9, done at T+10, dom_on=0.
- Redundant: req (d=0, on=0) with domain down -> done at T+1, clk_en/dom_reset unchanged.
- Back-to-back valid held during sequence -> req_ready low, second request accepted only after return to IDLE, other domains untouched.
- Assert reset at T+3 of an up sequence -> clk_en=0, dom_reset=1s, dom_on=0 immediately; clean restart after release.
- CLKSEQ_BOOT_EN, N=5, SETTLE=4 -> five done pulses for domains 0..4 spaced 6 cycles apart; req_ready rises after the fifth; dom_on=5'b11111.
